junction_controller: RTL
========================

JUNCTION_CONTROLLER -- requirements
Module: junction_controller

Interface
REQ-001 The block SHALL have parameter T_GREEN, default 8: green dwell, in clock cycles.
REQ-002 The block SHALL have parameter T_AMBER, default 2: amber dwell.
REQ-003 The block SHALL have parameter T_RED_AMBER, default 2: red+amber dwell.
REQ-004 The block SHALL have parameter T_ALLRED, default 1: all-red clearance dwell.
REQ-005 The block SHALL have parameter T_WALK, default 4: pedestrian walk dwell.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port ped_req, input, 1 bit: pedestrian crossing request, sampled every cycle.
REQ-009 The block SHALL have port ped_ack, output, 1 bit: one-cycle pulse when a request is serviced.
REQ-010 The block SHALL have ports ns_red, ns_amber, ns_green, outputs, 1 bit each: north-south lamp drives.
REQ-011 The block SHALL have ports ew_red, ew_amber, ew_green, outputs, 1 bit each: east-west lamp drives.
REQ-012 The block SHALL have port walk, output, 1 bit: pedestrian walk lamp.

Function
REQ-013 The block SHALL use a Moore FSM; all outputs SHALL be registered or decoded only from the state register.
REQ-014 The FSM states SHALL be NS_GREEN, NS_AMBER, ALLRED_A, EW_RED_AMBER, EW_GREEN, EW_AMBER, ALLRED_B, NS_RED_AMBER and WALK.
REQ-015 The base sequence SHALL be NS_RED_AMBER -> NS_GREEN -> NS_AMBER -> ALLRED_A -> EW_RED_AMBER -> EW_GREEN -> EW_AMBER -> ALLRED_B -> NS_RED_AMBER.
REQ-016 Each state SHALL be occupied for exactly its parameter's number of cycles: RED_AMBER states for T_RED_AMBER, GREEN states for T_GREEN, AMBER states for T_AMBER, ALLRED states for T_ALLRED, and WALK for T_WALK.
REQ-017 A down-counter SHALL reload on state entry, and the transition SHALL occur when it reaches 0.
REQ-018 The counter width SHALL cover the largest parameter; every parameter value SHALL be at least 1.
REQ-019 In each direction, the lamp decode SHALL be: green state = green only; amber state = amber only; red-amber state = red+amber; any other state = red only.
REQ-020 The two directions SHALL never show green or amber simultaneously; at least one direction SHALL be red in every cycle.
REQ-021 A ped_req high in any cycle SHALL set a sticky pending flag.
REQ-022 When an ALLRED dwell expires and pending=1, the FSM SHALL enter WALK instead of the next RED_AMBER state.
REQ-023 On exiting WALK, the FSM SHALL resume at the RED_AMBER state that was skipped.
REQ-024 In WALK, both directions SHALL be red only and walk=1; walk SHALL be 0 in all other states.
REQ-025 ped_ack SHALL pulse high for one cycle on the first WALK cycle, and pending SHALL clear at that edge.
REQ-026 A ped_req high in the same cycle as ped_ack, or at any later time, SHALL set pending again for the next service.
REQ-027 A request SHALL never interrupt a green or amber phase early.

Reset
REQ-028 While rst_n=0, the FSM SHALL asynchronously enter ALLRED_B, with the counter loaded to T_ALLRED, pending=0, ns_red=ew_red=1, all other lamps 0, walk=0 and ped_ack=0.
REQ-029 After reset release, the first transition SHALL be to NS_RED_AMBER after T_ALLRED cycles.
REQ-030 A reset asserted mid-phase, including during WALK, SHALL abandon that phase immediately and discard pending.

Configuration
REQ-031 When macro PED_CROSSING_EN is defined, the WALK state, the pending flag and the walk/ped_ack behaviour SHALL be compiled in.
REQ-032 When PED_CROSSING_EN is undefined, ped_req SHALL be ignored, walk and ped_ack SHALL be tied to 0, the WALK state SHALL be absent, and the base sequence SHALL run unchanged.

Verification
REQ-033 The bench SHALL cover: defaults, no ped_req, 60 cycles after reset release -> NS_RED_AMBER entered at cycle 1, and a 26-cycle period repeating NS green 8 / amber 2 / all-red 1 / EW red+amber 2 / EW green 8 / amber 2 / all-red 1 / NS red+amber 2.
REQ-034 The bench SHALL cover: ped_req pulsed for 1 cycle during NS_GREEN -> WALK entered after ALLRED_A, walk=1 for 4 cycles, ped_ack one pulse, then EW_RED_AMBER.
REQ-035 The bench SHALL cover: ped_req held high continuously -> WALK after every ALLRED state, and a new ped_ack each service.
REQ-036 The bench SHALL cover: rst_n dropped on the 2nd cycle of WALK -> all outputs at reset values in the same cycle; after release, NS_RED_AMBER follows with no WALK.
REQ-037 The bench SHALL assert every cycle, for all tests, that no green/amber conflict occurs between NS and EW, and that walk=1 implies both directions are red only.
REQ-038 The bench SHALL cover: compiled without PED_CROSSING_EN, ped_req toggling -> timing identical to the REQ-033 run, with walk=0 and ped_ack=0 throughout.

Source files
------------

// File: rtl/junction_controller.sv
// junction_controller: two-way signal FSM with an optional pedestrian WALK phase.
// Define PED_CROSSING_EN to compile in WALK, the pending flag, walk and ped_ack.
module junction_controller #(
    parameter int unsigned T_GREEN     = 8,
    parameter int unsigned T_AMBER     = 2,
    parameter int unsigned T_RED_AMBER = 2,
    parameter int unsigned T_ALLRED    = 1,
    parameter int unsigned T_WALK      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_req,
    output logic ped_ack,
    output logic ns_red,
    output logic ns_amber,
    output logic ns_green,
    output logic ew_red,
    output logic ew_amber,
    output logic ew_green,
    output logic walk
);

    localparam int unsigned M1    = (T_GREEN > T_AMBER) ? T_GREEN : T_AMBER;
    localparam int unsigned M2    = (M1 > T_RED_AMBER) ? M1 : T_RED_AMBER;
    localparam int unsigned M3    = (M2 > T_ALLRED) ? M2 : T_ALLRED;
    localparam int unsigned T_MAX = (M3 > T_WALK) ? M3 : T_WALK;
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        NS_GREEN,
        NS_AMBER,
        ALLRED_A,
        EW_RED_AMBER,
        EW_GREEN,
        EW_AMBER,
        ALLRED_B,
`ifdef PED_CROSSING_EN
        NS_RED_AMBER,
        WALK
`else
        NS_RED_AMBER
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ns_lamp, ew_lamp;

    // Counter holds the cycles left in the current state, including this one.
    function automatic logic [CW-1:0] dwell(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:         dwell = CW'(T_GREEN);
            NS_AMBER, EW_AMBER:         dwell = CW'(T_AMBER);
            NS_RED_AMBER, EW_RED_AMBER: dwell = CW'(T_RED_AMBER);
`ifdef PED_CROSSING_EN
            WALK:                       dwell = CW'(T_WALK);
`endif
            default:                    dwell = CW'(T_ALLRED);
        endcase
    endfunction

`ifdef PED_CROSSING_EN
    logic pend_q, pend_d;
    logic ack_q, ack_d;
    logic resume_ew_q, resume_ew_d;
    logic enter_walk;
`else
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALLRED_B;
            cnt_q   <= CW'(T_ALLRED);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
            case (state_q)
                NS_RED_AMBER: state_d = NS_GREEN;
                NS_GREEN:     state_d = NS_AMBER;
                NS_AMBER:     state_d = ALLRED_A;
                ALLRED_A:     state_d = EW_RED_AMBER;
                EW_RED_AMBER: state_d = EW_GREEN;
                EW_GREEN:     state_d = EW_AMBER;
                EW_AMBER:     state_d = ALLRED_B;
                ALLRED_B:     state_d = NS_RED_AMBER;
`ifdef PED_CROSSING_EN
                WALK:         state_d = resume_ew_q ? EW_RED_AMBER : NS_RED_AMBER;
`endif
                default:      state_d = ALLRED_B;
            endcase
`ifdef PED_CROSSING_EN
            if ((state_q == ALLRED_A || state_q == ALLRED_B) && pend_q)
                state_d = WALK;
`endif
            cnt_d = dwell(state_d);
        end
    end

`ifdef PED_CROSSING_EN
    assign enter_walk = (state_d == WALK) && (state_q != WALK);

    // A request seen on the entry edge is absorbed by the walk it triggers.
    always_comb begin
        pend_d      = enter_walk ? 1'b0 : (pend_q | ped_req);
        ack_d       = enter_walk;
        resume_ew_d = enter_walk ? (state_q == ALLRED_A) : resume_ew_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            resume_ew_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            resume_ew_q <= resume_ew_d;
        end
    end

    assign ped_ack = ack_q;
    assign walk    = (state_q == WALK);
`else
    assign ped_ack = 1'b0;
    assign walk    = 1'b0;
`endif

    always_comb begin
        ns_lamp = 3'b100;
        ew_lamp = 3'b100;
        case (state_q)
            NS_RED_AMBER: ns_lamp = 3'b110;
            NS_GREEN:     ns_lamp = 3'b001;
            NS_AMBER:     ns_lamp = 3'b010;
            EW_RED_AMBER: ew_lamp = 3'b110;
            EW_GREEN:     ew_lamp = 3'b001;
            EW_AMBER:     ew_lamp = 3'b010;
            default:      ;
        endcase
    end

    assign {ns_red, ns_amber, ns_green} = ns_lamp;
    assign {ew_red, ew_amber, ew_green} = ew_lamp;

endmodule
